// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock over WIDTH+1 bit
// extended operands, with valid/ready handshakes on both the operand and result sides.
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     inp_a,
    input  logic [WIDTH-1:0]     inp_b,
    input  logic                 signed_mode,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH:0]      a_q, a_d;
    logic [WIDTH:0]      q_q, q_d;
    logic                q1_q, q1_d;
    logic [WIDTH:0]      m_q, m_d;
    logic [WIDTH:0]      mneg_q, mneg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  result_q, result_d;

    logic [WIDTH:0]      ext_a, ext_b, neg_b;
    logic [WIDTH:0]      a_sum, a_sh, q_sh;

    // The extra top bit lets unsigned operands run through the signed Booth datapath.
    assign ext_a = {signed_mode & inp_a[WIDTH-1], inp_a};
    assign ext_b = {signed_mode & inp_b[WIDTH-1], inp_b};
    assign neg_b = {(WIDTH+1){1'b0}} - ext_b;

    always_comb begin
        case ({q_q[0], q1_q})
            2'b10:   a_sum = a_q + mneg_q;
            2'b01:   a_sum = a_q + m_q;
            default: a_sum = a_q;
        endcase
        a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_sh = {a_sum[0], q_q[WIDTH:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        mneg_d   = mneg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !clear) begin
                    a_d     = '0;
                    q_d     = ext_a;
                    q1_d    = 1'b0;
                    m_d     = ext_b;
                    mneg_d  = neg_b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    a_d   = a_sh;
                    q_d   = q_sh;
                    q1_d  = q_q[0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // Low 2*WIDTH bits of {A,Q}: all of Q plus the low WIDTH-1 bits of A.
                        result_d = {a_sh[WIDTH-2:0], q_sh};
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (clear || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            mneg_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            mneg_q   <= mneg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign result    = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8 and WIDTH=16; expected products are queued
// by the stimulus and popped by per-instance monitors on each output handshake.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, signed_mode, clear, out_ready;
    logic [7:0]  inp_a, inp_b;
    logic        in_ready, out_valid, busy;
    logic [15:0] result;

    logic        in_valid_w, signed_mode_w, clear_w, out_ready_w;
    logic [15:0] inp_a_w, inp_b_w;
    logic        in_ready_w, out_valid_w, busy_w;
    logic [31:0] result_w;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inp_a(inp_a), .inp_b(inp_b), .signed_mode(signed_mode), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .inp_a(inp_a_w), .inp_b(inp_b_w), .signed_mode(signed_mode_w), .clear(clear_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w), .busy(busy_w)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];
    logic [31:0] exp16_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-bit instance: latency of each op and in-order result checking.
    logic ov8_prev = 1'b0;
    int   acc8     = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready && !clear) acc8 = cyc + 1;
            if (out_valid && !ov8_prev) check("latency8", cyc - acc8, 9);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected8: result %0h presented, expected no output", result);
                end else begin
                    check("result8", result, exp_q.pop_front());
                end
            end
        end
        ov8_prev = out_valid;
    end

    logic ov16_prev = 1'b0;
    int   acc16     = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid_w && in_ready_w && !clear_w) acc16 = cyc + 1;
            if (out_valid_w && !ov16_prev) check("latency16", cyc - acc16, 17);
            if (out_valid_w && out_ready_w) begin
                if (exp16_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected16: result %0h presented, expected no output", result_w);
                end else begin
                    check("result16", result_w, exp16_q.pop_front());
                end
            end
        end
        ov16_prev = out_valid_w;
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, output int acc);
        int t;
        t = 0;
        in_valid = 1'b1;
        inp_a = a;
        inp_b = b;
        signed_mode = s;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept8_timeout: in_ready low for %0d cycles, expected accept", t);
        end
        tick();
        acc = cyc;
        in_valid = 1'b0;
        inp_a = 8'($urandom);
        inp_b = 8'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int t;
        t = 0;
        in_valid_w = 1'b1;
        inp_a_w = a;
        inp_b_w = b;
        signed_mode_w = s;
        while (!in_ready_w && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept16_timeout: in_ready low for %0d cycles, expected accept", t);
        end
        tick();
        in_valid_w = 1'b0;
        inp_a_w = 16'($urandom);
        inp_b_w = 16'($urandom);
        signed_mode_w = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp16_q.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0",
                     exp_q.size(), exp16_q.size());
        end
        tick();
    endtask

    logic [7:0]  va[7] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'hC8, 8'hFF, 8'hC8};
    logic [7:0]  vb[7] = '{8'h80, 8'hFF, 8'hB3, 8'hFF, 8'h03, 8'hFF, 8'h03};
    logic        vs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ve[7] = '{16'h4000, 16'hFF81, 16'h0000, 16'hFE01, 16'h0258, 16'h0001, 16'hFF58};

    initial begin
        int acc_a, acc_b, acc_c, hs, t;
        rst_n = 1'b0;
        in_valid = 1'b0; inp_a = '0; inp_b = '0; signed_mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; inp_a_w = '0; inp_b_w = '0; signed_mode_w = 1'b0; clear_w = 1'b0;
        out_ready_w = 1'b1;
        repeat (3) tick();

        check("rst_in_ready8", in_ready, 1);
        check("rst_out_valid8", out_valid, 0);
        check("rst_busy8", busy, 0);
        check("rst_result8", result, 0);
        check("rst_in_ready16", in_ready_w, 1);
        check("rst_result16", result_w, 0);
        rst_n = 1'b1;
        tick();

        // Wide instance runs alongside the 8-bit directed vectors.
        exp16_q.push_back(32'h40000000);
        issue16(16'h8000, 16'h8000, 1'b1);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ve[i]);
            issue8(va[i], vb[i], vs[i], acc_a);
        end

        exp16_q.push_back(32'hFFFE0001);
        issue16(16'hFFFF, 16'hFFFF, 1'b0);
        drain();

        // Back-to-back with out_ready high: accepts spaced WIDTH+3 cycles apart.
        exp_q.push_back(16'h001E);
        issue8(8'd5, 8'd6, 1'b1, acc_a);
        exp_q.push_back(16'hFFEB);
        issue8(8'hFD, 8'd7, 1'b1, acc_b);
        exp_q.push_back(16'hD8F0);
        issue8(8'd100, 8'h9C, 1'b1, acc_c);
        check("b2b_spacing_1", acc_b - acc_a, 11);
        check("b2b_spacing_2", acc_c - acc_b, 11);
        drain();

        // Backpressure: result held, new request ignored until the output handshake.
        out_ready = 1'b0;
        exp_q.push_back(16'h0084);
        issue8(8'd12, 8'd11, 1'b0, acc_a);
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        check("bp_out_valid_rise", out_valid, 1);
        in_valid = 1'b1; inp_a = 8'd9; inp_b = 8'd9; signed_mode = 1'b0;
        exp_q.push_back(16'h0051);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 16'h0084);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        hs = cyc;
        issue8(8'd9, 8'd9, 1'b0, acc_a);
        check("bp_accept_after_idle", acc_a - hs, 2);
        drain();

        // Abort in RUN: no output, last completed result retained.
        issue8(8'h55, 8'h33, 1'b1, acc_a);
        repeat (3) tick();
        check("abort_busy_before", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result_kept", result, 16'h0051);
        repeat (12) tick();
        check("abort_no_output", out_valid, 0);

        // clear in IDLE blocks a simultaneous request.
        clear = 1'b1;
        in_valid = 1'b1; inp_a = 8'd3; inp_b = 8'd3;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_idle_no_accept", busy, 0);
        repeat (12) tick();

        // Asynchronous reset mid-RUN takes effect before any clock edge.
        issue8(8'h11, 8'h22, 1'b0, acc_a);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        tick();
        rst_n = 1'b1;
        tick();

        exp_q.push_back(16'h0019);
        issue8(8'd5, 8'd5, 1'b0, acc_a);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
